// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame/baud parameters.
// Used by uart_rx and intended for reuse by the matching transmitter.
package uart_pkg;

    localparam int DBIT_DEF = 8;
    localparam int OVS_DEF  = 16;
    localparam int DVSR_DEF = 54;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Counter width helper that never returns zero, so 1-valued ranges still get a bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: free-running 0..DVSR-1 counter, s_tick high for
// one clk while the count sits at DVSR-1.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DVSR = DVSR_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic s_tick
);

    localparam int CW = clog2_min1(DVSR);

    logic [CW-1:0] cnt;

    assign s_tick = (cnt == CW'(DVSR - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (s_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start, DBIT data LSB-first, optional even parity, stop).
// Define UART_RX_PARITY_EN to receive and check a parity bit after the data bits.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | counting to the middle of the start bit, reject glitches
// DATA   | sampling DBIT data bits at their mid-points
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then report the frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEF,
    parameter int DVSR = DVSR_DEF,
    parameter int OVS  = OVS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int SW = clog2_min1(OVS);
    localparam int NW = clog2_min1(DBIT);
    localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_END  = SW'(OVS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            s_tick;
    logic            rx_meta;
    logic            rx_s;
    logic            rx_prev;
    logic            rx_fall;

    rx_state_t       state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;

    logic            done_set;
    logic            par_bad;

    uart_baud_gen #(.DVSR(DVSR)) u_baud_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_tick (s_tick)
    );

    // rx is asynchronous; both flops reset to the idle level so release does not look like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign rx_fall = rx_prev & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic p_reg, p_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg <= 1'b0;
        end else begin
            p_reg <= p_next;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
`ifdef UART_RX_PARITY_EN
        p_next     = p_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (rx_fall) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_MID) begin
                        s_next = '0;
                        n_next = '0;
                        state_next = rx_s ? IDLE : DATA;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_END) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_END) begin
                        p_next     = rx_s;
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_END) begin
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        done_set = (state_reg == STOP) && s_tick && (s_reg == S_END);
`ifdef UART_RX_PARITY_EN
        par_bad  = ^{b_reg, p_reg};
`else
        par_bad  = 1'b0;
`endif
    end

    // Error flags are only ever set alongside the done pulse, so they read 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            rx_done_tick <= done_set;
            frame_err    <= done_set & ~rx_s;
            parity_err   <= done_set & par_bad;
            if (done_set) begin
                dout <= b_reg;
            end
        end
    end

endmodule
